// File: rtl/step_accumulator.sv
// step_accumulator
//   Registered accumulator. On each enabled cycle it adds or subtracts a
//   programmable step, modulo LIMIT+1. In wrap mode it wraps around; in
//   saturate mode it sticks at 0 or LIMIT. It also has a synchronous load,
//   a one-cycle terminal-count pulse, a sticky overflow flag and a
//   saturating event counter.
//
// Parameters
//   WIDTH  : accumulator, step and load width
//   LIMIT  : largest legal accumulator value (1 .. 2**WIDTH-1)
//   ECNT_W : width of the saturating event counter
//
// Ports
//   ck      in   clock, rising edge
//   clr     in   synchronous active-high clear; wins over everything
//   en      in   count enable
//   dn      in   0 = add step, 1 = subtract step
//   sat     in   0 = wrap modulo LIMIT+1, 1 = saturate at 0 / LIMIT
//   step    in   step value (clamped to LIMIT)
//   ld      in   synchronous load strobe; beats en
//   ld_val  in   load value (clamped to LIMIT)
//   ovf_clr in   clears ovf; a same-cycle event wins
//   q       out  accumulator value
//   tc      out  one-cycle pulse after a wrap/saturate event
//   ovf     out  sticky event flag
//   ecnt    out  saturating count of events
module step_accumulator #(
  parameter int WIDTH  = 8,
  parameter int LIMIT  = 2**WIDTH-1,
  parameter int ECNT_W = 4
) (
  input  logic              ck,
  input  logic              clr,
  input  logic              en,
  input  logic              dn,
  input  logic              sat,
  input  logic [WIDTH-1:0]  step,
  input  logic              ld,
  input  logic [WIDTH-1:0]  ld_val,
  input  logic              ovf_clr,
  output logic [WIDTH-1:0]  q,
  output logic              tc,
  output logic              ovf,
  output logic [ECNT_W-1:0] ecnt
);

  // All arithmetic is done one bit wider than the accumulator, so sums up to
  // 2*LIMIT and the modulus LIMIT+1 are represented without truncation.
  localparam logic [WIDTH:0]   LIM_X = (WIDTH+1)'(LIMIT);
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(LIMIT + 1);
  localparam logic [WIDTH-1:0] LIM_W = WIDTH'(LIMIT);

  logic [WIDTH-1:0]  q_q, q_d;
  logic              tc_q, tc_d;
  logic              ovf_q, ovf_d;
  logic [ECNT_W-1:0] ecnt_q, ecnt_d;

  logic [WIDTH:0]    q_x;
  logic [WIDTH:0]    s_x;
  logic [WIDTH:0]    sum_x;
  logic [WIDTH:0]    wrap_x;
  logic [WIDTH-1:0]  ld_c;
  logic [WIDTH-1:0]  cnt_res;
  logic              cnt_event;

  // Count datapath: next value and event flag for an enabled cycle.
  always_comb begin
    q_x       = {1'b0, q_q};
    s_x       = ({1'b0, step} > LIM_X) ? LIM_X : {1'b0, step};
    ld_c      = ({1'b0, ld_val} > LIM_X) ? LIM_W : ld_val;
    sum_x     = '0;
    wrap_x    = '0;
    cnt_res   = q_q;
    cnt_event = 1'b0;
    if (!dn) begin
      sum_x = q_x + s_x;
      if (sum_x > LIM_X) begin
        cnt_event = 1'b1;
        wrap_x    = sum_x - MOD_X;
        cnt_res   = sat ? LIM_W : wrap_x[WIDTH-1:0];
      end else begin
        cnt_res = sum_x[WIDTH-1:0];
      end
    end else begin
      if (q_x >= s_x) begin
        sum_x   = q_x - s_x;
        cnt_res = sum_x[WIDTH-1:0];
      end else begin
        // q < s here, so q + (LIMIT+1) - s lies in 0..LIMIT.
        cnt_event = 1'b1;
        wrap_x    = q_x + MOD_X - s_x;
        cnt_res   = sat ? '0 : wrap_x[WIDTH-1:0];
      end
    end
  end

  // Next-state selection: ld beats en. ovf_clr is applied first, so an
  // event in the same cycle sets ovf again.
  always_comb begin
    q_d    = q_q;
    tc_d   = 1'b0;
    ovf_d  = ovf_q & ~ovf_clr;
    ecnt_d = ecnt_q;
    if (ld) begin
      q_d = ld_c;
    end else if (en) begin
      q_d = cnt_res;
      if (cnt_event) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
        if (ecnt_q != '1) begin
          ecnt_d = ecnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge ck) begin
    if (clr) begin
      q_q    <= '0;
      tc_q   <= 1'b0;
      ovf_q  <= 1'b0;
      ecnt_q <= '0;
    end else begin
      q_q    <= q_d;
      tc_q   <= tc_d;
      ovf_q  <= ovf_d;
      ecnt_q <= ecnt_d;
    end
  end

  assign q    = q_q;
  assign tc   = tc_q;
  assign ovf  = ovf_q;
  assign ecnt = ecnt_q;

endmodule
